// File: rtl/mic_pkg.sv
// Shared constants and FSM state type for the microphone level meter.
package mic_pkg;
   localparam int SAMPLE_W  = 18;
   localparam int N_SAMPLES = 16;
   localparam int N_LEDS    = 10;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      SCAN,
      MAP,
      UPDATE
   } meter_state_t;
endpackage

// File: rtl/msb_to_level.sv
// Priority encoder: maps a frame's peak magnitude onto a log2 bar level 0..N_LEDS.
module msb_to_level #(
   parameter int SAMPLE_W = mic_pkg::SAMPLE_W,
   parameter int N_LEDS   = mic_pkg::N_LEDS
) (
   input  logic [SAMPLE_W-2:0] peak,
   output logic [3:0]          new_level
);
   // Each bar step is one octave; the quietest OFFSET octaves show nothing.
   localparam int OFFSET = SAMPLE_W - 1 - N_LEDS;

   int msb;

   always_comb begin
      msb = -1;
      for (int i = 0; i < SAMPLE_W - 1; i++) begin
         if (peak[i]) msb = i;
      end
      new_level = '0;
      if (msb >= 0 && msb >= OFFSET) new_level = 4'(msb - OFFSET + 1);
   end
endmodule

// File: rtl/mic_level_meter.sv
// Peak-hold LED bar meter: captures a mic_sampler frame, finds its peak |sample|,
// converts it to a log2 level and drives a thermometer bar with hold/decay.
module mic_level_meter #(
   parameter int SAMPLE_W    = mic_pkg::SAMPLE_W,
   parameter int N_SAMPLES   = mic_pkg::N_SAMPLES,
   parameter int N_LEDS      = mic_pkg::N_LEDS,
   parameter int HOLD_FRAMES = 4
) (
   input  logic                          clk_25,
   input  logic                          rst,
   input  logic                          done,
   input  logic [N_SAMPLES*SAMPLE_W-1:0] samples,
   output logic [N_LEDS-1:0]             leds,
   output logic [3:0]                    level,
   output logic                          level_valid,
   output logic                          busy,
   output logic [7:0]                    dropped
);
   import mic_pkg::*;

   localparam int IDX_W  = $clog2(N_SAMPLES);
   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_SAMPLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

   meter_state_t               state;
   logic                       done_q;
   logic                       frame_start;
   logic [IDX_W-1:0]           idx;
   logic [HOLD_W-1:0]          hold_cnt;
   logic signed [SAMPLE_W-1:0] frame_buf [N_SAMPLES];
   logic [SAMPLE_W-2:0]        peak;
   logic [SAMPLE_W-2:0]        mag;
   logic [3:0]                 enc_level;
   logic [3:0]                 map_level;
   logic [3:0]                 upd_level;
   logic [HOLD_W-1:0]          upd_hold;

   // Magnitude in SAMPLE_W-1 bits; the most negative code cannot be negated, so it clips.
   function automatic logic [SAMPLE_W-2:0] abs_sat(input logic signed [SAMPLE_W-1:0] x);
      logic signed [SAMPLE_W-1:0] neg;
      neg = -x;
      if (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) return '1;
      else if (x[SAMPLE_W-1])               return neg[SAMPLE_W-2:0];
      else                                   return x[SAMPLE_W-2:0];
   endfunction

   function automatic logic [N_LEDS-1:0] thermo(input logic [3:0] lvl);
      logic [N_LEDS-1:0] t;
      for (int i = 0; i < N_LEDS; i++) t[i] = (i < int'(lvl));
      return t;
   endfunction

   assign frame_start = done & ~done_q;
   assign mag         = abs_sat(frame_buf[idx]);

   msb_to_level #(
      .SAMPLE_W (SAMPLE_W),
      .N_LEDS   (N_LEDS)
   ) u_msb_to_level (
      .peak      (peak),
      .new_level (enc_level)
   );

   // Louder frames take over at once; quieter ones only pull the bar down one step per hold period.
   always_comb begin
      upd_level = level;
      upd_hold  = hold_cnt;
      if (map_level >= level) begin
         upd_level = map_level;
         upd_hold  = '0;
      end else if (hold_cnt == HOLD_LAST) begin
         upd_level = level - 4'd1;
         upd_hold  = '0;
      end else begin
         upd_hold  = hold_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_25 or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         done_q      <= 1'b1;
         idx         <= '0;
         hold_cnt    <= '0;
         level       <= '0;
         leds        <= '0;
         level_valid <= 1'b0;
         busy        <= 1'b0;
         dropped     <= '0;
      end else begin
         done_q      <= done;
         level_valid <= 1'b0;
         if (frame_start && state != IDLE && dropped != 8'hFF) dropped <= dropped + 8'd1;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  state <= CAPTURE;
                  busy  <= 1'b1;
               end
            end
            CAPTURE: begin
               idx   <= '0;
               state <= SCAN;
            end
            SCAN: begin
               if (idx == IDX_LAST) state <= MAP;
               else                 idx   <= idx + 1'b1;
            end
            MAP: begin
               state <= UPDATE;
            end
            UPDATE: begin
               level       <= upd_level;
               leds        <= thermo(upd_level);
               hold_cnt    <= upd_hold;
               level_valid <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // capture / scan / map datapath
   always_ff @(posedge clk_25) begin
      case (state)
         CAPTURE: begin
            for (int i = 0; i < N_SAMPLES; i++) frame_buf[i] <= samples[i*SAMPLE_W +: SAMPLE_W];
            peak <= '0;
         end
         SCAN: begin
            if (mag > peak) peak <= mag;
         end
         MAP: begin
            map_level <= enc_level;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mic_level_meter.sv
// Directed bench for mic_level_meter: latency, level mapping, hold/decay, overruns, reset.
module tb_mic_level_meter;
   localparam int SW = 18;
   localparam int NS = 16;
   localparam int NL = 10;

   logic              clk_25 = 1'b0;
   logic              rst;
   logic              done;
   logic [NS*SW-1:0]  samples;
   logic [NL-1:0]     leds;
   logic [3:0]        level;
   logic              level_valid;
   logic              busy;
   logic [7:0]        dropped;

   int checks = 0;
   int errors = 0;

   mic_level_meter dut (
      .clk_25      (clk_25),
      .rst         (rst),
      .done        (done),
      .samples     (samples),
      .leds        (leds),
      .level       (level),
      .level_valid (level_valid),
      .busy        (busy),
      .dropped     (dropped)
   );

   always #20 clk_25 = ~clk_25;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [NS*SW-1:0] put(input logic [NS*SW-1:0] f, input int i,
                                            input logic [SW-1:0] v);
      f[i*SW +: SW] = v;
      return f;
   endfunction

   // Called #1 after a rising edge; returns edges until level_valid is seen (-1 on timeout).
   task automatic run_frame(input logic [NS*SW-1:0] v, input int rerise_at, output int lat);
      samples = v;
      done    = 1'b1;
      lat     = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk_25); #1;
         if (level_valid) begin
            lat = n;
            break;
         end
         if (n == 1) check("busy_c1", busy, 1);
         if (n == 1) done = 1'b0;
         if (n == rerise_at) begin
            done    = 1'b1;
            samples = ~v;
         end
         if (n == rerise_at + 1) done = 1'b0;
      end
   endtask

   int lat;
   int seen;
   logic [NS*SW-1:0] f;
   int decay_exp [8] = '{10, 10, 10, 9, 9, 9, 9, 8};

   initial begin
      rst     = 1'b1;
      done    = 1'b1;
      samples = '0;
      repeat (3) @(posedge clk_25);
      #1;
      check("rst_leds", leds, 0);
      check("rst_level", level, 0);
      check("rst_valid", level_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_dropped", dropped, 0);
      rst = 1'b0;
      repeat (5) @(posedge clk_25);
      #1;
      check("done_high_at_release", busy, 0);
      done = 1'b0;
      @(posedge clk_25); #1;

      // silent frame
      run_frame('0, 0, lat);
      check("t1_latency", lat, 20);
      check("t1_level", level, 0);
      check("t1_leds", leds, 10'h000);
      check("t1_busy_c20", busy, 0);

      // small peaks: 200 -> 1, then 300 -> 2
      f = put(put('0, 0, 18'd200), 15, -18'sd100);
      run_frame(f, 0, lat);
      check("t3a_latency", lat, 20);
      check("t3a_level", level, 1);
      check("t3a_leds", leds, 10'h001);
      run_frame(put('0, 3, -18'sd300), 0, lat);
      check("t3b_level", level, 2);
      check("t3b_leds", leds, 10'h003);

      // most negative sample saturates to full scale
      run_frame(put('0, 5, 18'h20000), 0, lat);
      check("t2_latency", lat, 20);
      check("t2_level", level, 10);
      check("t2_leds", leds, 10'h3FF);

      // hold then decay with silent frames
      for (int i = 0; i < 8; i++) begin
         run_frame('0, 0, lat);
         check($sformatf("t4_decay%0d", i), level, decay_exp[i]);
      end
      run_frame('0, 0, lat);
      check("t4_hold1", level, 8);
      run_frame(put('0, 0, 18'd16384), 0, lat);
      check("t4_equal_frame", level, 8);
      for (int i = 0; i < 3; i++) begin
         run_frame('0, 0, lat);
         check($sformatf("t4_rehold%0d", i), level, 8);
      end
      run_frame('0, 0, lat);
      check("t4_redecay", level, 7);
      check("t4_redecay_leds", leds, 10'h07F);

      // overrun during SCAN
      rst = 1'b1;
      #2;
      check("t5_rst_level", level, 0);
      rst = 1'b0;
      @(posedge clk_25); #1;
      run_frame(put('0, 0, 18'd1000), 8, lat);
      check("t5_latency", lat, 20);
      check("t5_level", level, 3);
      check("t5_leds", leds, 10'h007);
      check("t5_dropped", dropped, 1);
      for (int i = 0; i < 800; i++) begin
         samples = put('0, 0, 18'(i));
         done    = ~done;
         @(posedge clk_25); #1;
      end
      repeat (25) @(posedge clk_25);
      #1;
      check("t5_dropped_sat", dropped, 255);
      check("t5_idle", busy, 0);

      // reset in the middle of SCAN
      run_frame(put('0, 5, 18'h20000), 0, lat);
      check("t6_pre_level", level, 10);
      samples = put('0, 2, 18'h20000);
      done    = 1'b1;
      seen    = 0;
      for (int n = 1; n <= 5; n++) begin
         @(posedge clk_25); #1;
         if (level_valid) seen = 1;
         if (n == 1) done = 1'b0;
      end
      rst = 1'b1;
      #2;
      check("t6_leds", leds, 0);
      check("t6_level", level, 0);
      check("t6_busy", busy, 0);
      check("t6_dropped", dropped, 0);
      @(negedge clk_25);
      rst = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk_25); #1;
         if (level_valid) seen = 1;
      end
      check("t6_no_valid", seen, 0);
      run_frame(put('0, 0, 18'd200), 0, lat);
      check("t6_after_latency", lat, 20);
      check("t6_after_level", level, 1);
      check("t6_after_leds", leds, 10'h001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
